dmem_arbiter: RTL

Two-master arbiter that shares the single-port data memory (`DataMem`) between the CPU load/store path (master 0, driven by `EX` ALU address and register read data) and a program/data loader (master 1, burst-capable). It sits between those two requesters and `DataMem` and drives the memory's write enable, address and write data. It registers read data back to the owning master and generates a stall for the `PC` when the CPU is refused. Locked loader bursts are supported, and a bounded burst length guarantees the CPU cannot starve.

---
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port DataMem between the CPU (master 0) and a burst loader (master 1).
// Optional macro DMEM_ARB_RR_EN: round-robin FREE-state ties; default build gives the CPU fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  output logic              cpu_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_last,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] LP_CNT_YLD = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {ST_FREE = 2'd0, ST_LOCK1 = 2'd1, ST_YIELD = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_beat_cnt_nxt;
  logic [CNT_W-1:0]  w_beat_inc;
  logic              r_last_gnt;
  logic              w_m0_gnt;
  logic              w_m1_gnt;
  logic              w_m0_tie_win;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;

`ifdef DMEM_ARB_RR_EN
  // last_gnt==1 means the loader went last, so the CPU takes this tie.
  assign w_m0_tie_win = r_last_gnt;
`else
  assign w_m0_tie_win = 1'b1;
`endif

  assign w_beat_inc = r_beat_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_FREE;
      r_beat_cnt <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      if (w_m0_gnt)      r_last_gnt <= 1'b0;
      else if (w_m1_gnt) r_last_gnt <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_LOCK1: begin
        if (!m1_req || m1_last) begin
          w_state_nxt    = ST_FREE;
          w_beat_cnt_nxt = '0;
        end else begin
          // Count saturates so a burst that outlives an idle CPU still yields once it asks.
          w_beat_cnt_nxt = (r_beat_cnt == LP_CNT_MAX) ? r_beat_cnt : w_beat_inc;
          if ((r_beat_cnt >= LP_CNT_YLD) && m0_req) w_state_nxt = ST_YIELD;
        end
      end
      ST_YIELD: begin
        w_state_nxt    = ST_LOCK1;
        w_beat_cnt_nxt = '0;
      end
      default: begin
        if (w_m1_gnt && !m1_last) begin
          w_state_nxt    = ST_LOCK1;
          w_beat_cnt_nxt = CNT_W'(1);
        end else begin
          w_state_nxt    = ST_FREE;
          w_beat_cnt_nxt = '0;
        end
      end
    endcase
  end

  // An aborted lock (m1_req low) arbitrates exactly like FREE, where only the CPU can be asking.
  always_comb begin
    w_m0_gnt = 1'b0;
    w_m1_gnt = 1'b0;
    case (r_state)
      ST_LOCK1: begin
        if (m1_req) w_m1_gnt = 1'b1;
        else        w_m0_gnt = m0_req;
      end
      ST_YIELD: w_m0_gnt = m0_req;
      default: begin
        if (m0_req && m1_req) begin
          w_m0_gnt = w_m0_tie_win;
          w_m1_gnt = ~w_m0_tie_win;
        end else begin
          w_m0_gnt = m0_req;
          w_m1_gnt = m1_req;
        end
      end
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_m0_rvalid <= w_m0_gnt & ~m0_we;
      r_m1_rvalid <= w_m1_gnt & ~m1_we;
      if (w_m0_gnt && !m0_we) r_m0_rdata <= mem_rdata;
      if (w_m1_gnt && !m1_we) r_m1_rdata <= mem_rdata;
    end
  end

  assign m0_gnt    = w_m0_gnt;
  assign m1_gnt    = w_m1_gnt;
  assign cpu_stall = m0_req & ~w_m0_gnt;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;

endmodule
